// File: rtl/sim_uart_pkg.sv
// sim_uart_pkg: shared FSM state type and bit-timing helpers for the UART receiver.
package sim_uart_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_e;
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction
    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction
endpackage

// File: rtl/prim_fifo_sync.sv
// prim_fifo_sync: synchronous valid/ready FIFO; a full FIFO still accepts a write
// in a cycle where it is being popped. Pass=1 lets writes bypass an empty FIFO.
module prim_fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 4,
    parameter bit Pass  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);
    localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr, r_rptr;
    logic [CntW-1:0]  r_cnt;
    logic             w_empty, w_full, w_pass, w_push, w_pop;
    assign w_empty  = r_cnt == '0;
    assign w_full   = r_cnt == CntW'(Depth);
    assign w_pass   = Pass && w_empty;
    assign wready_o = !w_full || rready_i;
    assign rvalid_o = w_pass ? wvalid_i : !w_empty;
    // Empty head reads as zero so the data output is clean out of reset.
    assign rdata_o  = w_pass ? wdata_i : w_empty ? '0 : r_mem[r_rptr];
    assign w_push   = wvalid_i && wready_o && !(w_pass && rready_i);
    assign w_pop    = !w_empty && rready_i;
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wdata_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_wptr <= w_push ? (r_wptr == PtrW'(Depth - 1) ? '0 : r_wptr + 1'b1) : r_wptr;
            r_rptr <= w_pop ? (r_rptr == PtrW'(Depth - 1) ? '0 : r_rptr + 1'b1) : r_rptr;
            r_cnt  <= r_cnt + CntW'(w_push) - CntW'(w_pop);
        end
    end
endmodule

// File: rtl/prim_flop_2sync.sv
// prim_flop_2sync: two-flop synchronizer with a configurable reset value.
module prim_flop_2sync #(
    parameter int                Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] r_meta;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= ResetValue;
            q_o    <= ResetValue;
        end else begin
            r_meta <= d_i;
            q_o    <= r_meta;
        end
    end
endmodule

// File: rtl/sim_uart_rx.sv
// sim_uart_rx: 8N1 UART receiver sampling mid-bit, with a byte buffer on a
// valid/ready output and pulsed framing-error / overflow flags.
module sim_uart_rx import sim_uart_pkg::*; #(
    parameter int Freq      = 500_000,
    parameter int Baud      = 7_200,
    parameter int FifoDepth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);
    localparam int ClksPerBit = clks_per_bit(Freq, Baud);
    localparam int HalfBit    = half_bit(ClksPerBit);
    localparam int CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
    if (ClksPerBit < 4) begin : g_bad_baud
        $error("sim_uart_rx: Freq/Baud must give at least 4 clocks per bit");
    end
    if (FifoDepth < 2) begin : g_bad_depth
        $error("sim_uart_rx: FifoDepth must be at least 2");
    end
    state_e          r_state, w_next;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            w_rx, w_tick, w_load_half, w_load_full, w_shift, w_push, w_bad_stop, w_wready;
    prim_flop_2sync #(.Width(1), .ResetValue(1'b1)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx_i),
        .q_o    (w_rx)
    );
    assign w_tick = r_cnt == '0;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (enable_i && !w_rx) w_next = ST_START;
            ST_START: if (w_tick) w_next = w_rx ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_tick && r_idx == 3'd7) w_next = ST_STOP;
            ST_STOP:  if (w_tick) w_next = w_rx ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (w_rx) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        w_load_half = r_state == ST_IDLE && enable_i && !w_rx;
        w_load_full = w_tick && ((r_state == ST_START && !w_rx) || r_state == ST_DATA);
        w_shift     = w_tick && r_state == ST_DATA;
        w_push      = w_tick && r_state == ST_STOP && w_rx;
        w_bad_stop  = w_tick && r_state == ST_STOP && !w_rx;
        busy_o      = r_state != ST_IDLE;
    end
    // Counter only decrements while non-zero, so it can never wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            r_cnt       <= w_load_half ? CntHalf : w_load_full ? CntFull : !w_tick ? r_cnt - 1'b1 : r_cnt;
            r_idx       <= r_state == ST_START ? 3'd0 : w_shift ? r_idx + 3'd1 : r_idx;
            r_shift     <= w_shift ? {w_rx, r_shift[7:1]} : r_shift;
            frame_err_o <= w_bad_stop;
            overflow_o  <= w_push && !w_wready;
        end
    end
    prim_fifo_sync #(.Width(8), .Depth(FifoDepth), .Pass(1'b0)) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (w_push),
        .wready_o (w_wready),
        .wdata_i  (r_shift),
        .rvalid_o (rx_valid_o),
        .rready_i (rx_ready_i),
        .rdata_o  (rx_data_o)
    );
endmodule

// File: tb/tb_sim_uart_rx.sv
// tb_sim_uart_rx: scoreboard bench for sim_uart_rx at 8 clocks per bit.
module tb_sim_uart_rx;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, rx = 1'b1, rdy = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, ferr, ovf, busy;
    int         n_chk = 0, n_bad = 0, n_ferr = 0, n_ovf = 0, n_extra = 0;
    logic [7:0] exp_q[$];
    always #5 clk = ~clk;
    sim_uart_rx #(.Freq(800), .Baud(100), .FifoDepth(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (en),
        .rx_i        (rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rdy),
        .frame_err_o (ferr),
        .overflow_o  (ovf),
        .busy_o      (busy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input bit expd, input int drop_at);
        if (expd) exp_q.push_back(b);
        rx = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            if (i == drop_at) en = 1'b0;
            rx = b[i];
            tick(8);
        end
        rx = stop;
        tick(8);
        rx = 1'b1;
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) n_ferr++;
            if (ovf) n_ovf++;
            if (rx_valid && rdy) begin
                if (exp_q.size() == 0) n_extra++;
                else chk("byte", rx_data, exp_q.pop_front());
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end
    initial begin
        tick(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick(4);
        send(8'h55, 1'b1, 1'b1, -1);
        tick(2);
        chk("lat_55", exp_q.size(), 0);
        chk("ferr_55", n_ferr, 0);
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(2);
        chk("glitch_busy_mid", busy, 1);
        tick(10);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_bytes", n_extra, 0);
        send(8'hA3, 1'b0, 1'b0, -1);
        rx = 1'b0;
        tick(30);
        chk("brk_busy", busy, 1);
        rx = 1'b1;
        tick(4);
        chk("brk_exit", busy, 0);
        chk("ferr_cnt", n_ferr, 1);
        send(8'h01, 1'b1, 1'b1, -1);
        tick(2);
        chk("lat_01", exp_q.size(), 0);
        rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(8'(8'h10 + k), 1'b1, k < 4, -1);
            tick(2);
            chk("hold_data", rx_data, 8'h10);
        end
        chk("ovf_cnt", n_ovf, 2);
        chk("hold_valid", rx_valid, 1);
        chk("buffered", exp_q.size(), 4);
        rdy = 1'b1;
        tick(10);
        chk("drain", exp_q.size(), 0);
        chk("drain_valid", rx_valid, 0);
        rx = 1'b0;
        tick(8);
        rx = 1'b1;
        tick(3 * 8 + 4);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rx_valid, 0);
        rst_n = 1'b1;
        tick(40);
        send(8'h3C, 1'b1, 1'b1, -1);
        tick(2);
        chk("lat_3c", exp_q.size(), 0);
        en = 1'b0;
        send(8'h77, 1'b1, 1'b0, -1);
        tick(4);
        chk("dis_busy", busy, 0);
        en = 1'b1;
        tick(2);
        send(8'h42, 1'b1, 1'b1, 3);
        tick(2);
        chk("lat_42", exp_q.size(), 0);
        tick(10);
        chk("extra_bytes", n_extra, 0);
        chk("ferr_total", n_ferr, 1);
        chk("ovf_total", n_ovf, 2);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
